// File: rtl/codificador_seq.sv
// codificador_seq: sequencing controller for the 4-bit-to-5-bit encoder.
// Accepts a NIBBLES-nibble word over valid/ready and presents it to the
// encoder one nibble at a time, most-significant nibble first. Each nibble
// is held for a settle cycle (DRIVE) and then captured (SAMPLE). The codes
// are packed into out_code, with the first nibble's code in the MSBs.
// out_code is then held with out_valid until out_ack is seen.
//
// Optional build macro: CODIFICADOR_SEQ_PARITY_EN adds the out_parity output.
// out_parity is the XOR of all out_code bits.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | encoder held in reset, waiting for in_valid
// DRIVE  | top nibble driven to the encoder, settle cycle, no capture
// SAMPLE | same nibble still driven; enc_code is captured at the edge
// DONE   | codeword held with out_valid until out_ack

module codificador_seq #(
    parameter  int NIBBLES = 4,
    localparam int WORD_W  = 4 * NIBBLES,
    localparam int CODE_W  = 5 * NIBBLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        enc_nib,
    output logic              enc_ready,
    output logic              enc_reset,
    input  logic [4:0]        enc_code,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              busy
`ifdef CODIFICADOR_SEQ_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    // One extra bit keeps the counter from wrapping, including when NIBBLES is a power of two.
    localparam int CNT_W = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CODE_W-1:0]   code_q,  code_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    // State register and datapath registers. An asynchronous reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore outputs. The encoder stays in reset outside DRIVE and SAMPLE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        enc_ready = 1'b0;
        enc_reset = 1'b1;
        enc_nib   = 4'h0;
        out_valid = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    shift_d = in_word;
                    code_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                enc_reset = 1'b0;
                enc_ready = 1'b1;
                enc_nib   = shift_q[WORD_W-1 -: 4];
                state_d   = ST_SAMPLE;
            end

            ST_SAMPLE: begin
                enc_reset = 1'b0;
                enc_ready = 1'b1;
                enc_nib   = shift_q[WORD_W-1 -: 4];
                // Shifting by a constant, rather than slicing, keeps the single-nibble build legal.
                code_d    = (code_q << 5) | CODE_W'(enc_code);
                shift_d   = shift_q << 4;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_code = code_q;

`ifdef CODIFICADOR_SEQ_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity follows the next code value, so it changes on the same edge as out_code.
    always_comb begin
        parity_d = ^code_d;
    end

    // Parity register, cleared together with the code register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: doc/codificador_seq.md
Name: codificador_seq

Overview:
- Sequencing controller for the team's combinational 4-bit-to-5-bit encoder.
- Accepts a multi-nibble data word over a valid/ready handshake and presents its nibbles to the encoder one at a time, most-significant first.
- Drives the encoder's `ready` and `reset` pins and samples its 5-bit code after a settle cycle.
- Assembles the full codeword and holds it with `out_valid` until acknowledged.
- Sits between the upstream data source and the encoder instance.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per input word (≥1)
- WORD_W, 4*NIBBLES, derived input word width (localparam)
- CODE_W, 5*NIBBLES, derived codeword width (localparam)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_word  in  WORD_W  data word to encode
- in_valid  in  1  in_word valid
- in_ready  out  1  block can accept a word
- enc_nib  out  4  nibble to encoder: bit3→a, bit2→b, bit1→c, bit0→d
- enc_ready  out  1  to encoder `ready`
- enc_reset  out  1  to encoder `reset`
- enc_code  in  5  from encoder: bit4=m1 … bit0=m5
- out_code  out  CODE_W  assembled codeword; first nibble's code in the MSBs
- out_valid  out  1  out_code valid
- out_ack  in  1  consumer accepts out_code
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset asserted (asynchronous, any time, including mid-word):
  - state=IDLE, counter=0, shift registers=0
  - out_code=0, out_valid=0, enc_nib=0, enc_ready=0, enc_reset=1, busy=0, in_ready=1
  - any partial word is discarded.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - Outputs: in_ready=1, enc_reset=1, enc_ready=0.
  - On in_valid=1 at the clock edge: load in_word into the nibble shift register, clear the code register and counter, go to DRIVE.
- DRIVE:
  - Outputs: enc_reset=0, enc_ready=1, enc_nib=top nibble of the shift register.
  - Next edge: go to SAMPLE.
  - This is the settle cycle; no capture occurs.
- SAMPLE:
  - enc_nib and enc_ready are unchanged from DRIVE.
  - At the edge: out_code <= {out_code[CODE_W-6:0], enc_code}, shift the nibble register left by 4, counter += 1.
  - If counter == NIBBLES-1 before the increment, go to DONE; otherwise go to DRIVE.
- DONE:
  - Outputs: out_valid=1, enc_ready=0, enc_reset=1, in_ready=0.
  - out_code is held stable.
  - On out_ack=1: go to IDLE and clear out_valid. out_code keeps its value until the next accept.
- Timing:
  - Two cycles per nibble.
  - out_valid rises exactly 2*NIBBLES clock edges after the accept edge.
  - Minimum input-to-input period is 2*NIBBLES+2 cycles.
- Handshake rules:
  - in_ready is high only in IDLE. in_valid outside IDLE is ignored, with no buffering.
  - out_ack outside DONE is ignored.
  - in_valid and out_ack in the same DONE cycle: the block goes to IDLE; the word is accepted in a later IDLE cycle only if in_valid is still high.
- NIBBLES=1: one DRIVE/SAMPLE pair; out_valid two edges after accept.
- The counter is sized $clog2(NIBBLES)+1 bits and never wraps during a word.

Optional Feature:
- Macro: CODIFICADOR_SEQ_PARITY_EN.
- When defined:
  - Add output out_parity (1 bit) = XOR of all CODE_W bits of out_code.
  - It is updated together with out_code at each SAMPLE capture and is valid whenever out_valid=1.
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench encoder model (team encoding): 0→00000, 1→10000, 2→11000, 5→11111, 8→00011.
- Reset then idle:
  - Stimulus: reset high for 3 cycles, then low.
  - Required: in_ready=1, busy=0, enc_reset=1, out_valid=0, out_code=0.
- Single word:
  - Stimulus: NIBBLES=4, in_word=16'h1258 accepted.
  - Required: enc_nib sequence 1,1,2,2,5,5,8,8 (each held 2 cycles); out_valid rises 8 edges after accept; out_code=20'h863E3.
  - With the macro defined: out_parity=0.
- Hold until acknowledged:
  - Stimulus: out_ack held low for 5 cycles after out_valid, then pulsed.
  - Required: out_code stays 20'h863E3 and out_valid stays 1; the block returns to IDLE one edge after the ack.
- Ignored request while busy:
  - Stimulus: in_word=16'h0000 with in_valid high throughout the processing of 16'h1258.
  - Required: the first result is 20'h863E3 and is unaffected; 16'h0000 is accepted only in IDLE after the ack, giving out_code=0.
- Reset mid-operation:
  - Stimulus: async reset asserted in the SAMPLE cycle of the second nibble.
  - Required: immediately state=IDLE, out_valid=0, out_code=0; the next word 16'h5555 yields 20'hFFFFF (parity 0).
- Single-nibble configuration:
  - Stimulus: NIBBLES=1, in_word=4'h8.
  - Required: out_valid two edges after accept, out_code=5'b00011; parity 0 when the macro is defined.
